// File: rtl/pause_pkg.sv
// -----------------------------------------------------------------------------
// pause_pkg
// Shared definitions for the CPU pause synchroniser: FSM state encoding and
// parameter defaults used by pause_sync.
// No ports (package).
// -----------------------------------------------------------------------------
package pause_pkg;

    // FSM state encoding, kept as plain constants for legacy tool flows.
    typedef logic [2:0] pause_state_t;

    localparam pause_state_t ST_RUN       = 3'd0;
    localparam pause_state_t ST_DRAIN     = 3'd1;
    localparam pause_state_t ST_HALT_WAIT = 3'd2;
    localparam pause_state_t ST_PAUSED    = 3'd3;
    localparam pause_state_t ST_STEP      = 3'd4;

    // 1: wait for a vblank rising edge before starting a halt.
    localparam int unsigned ALIGN_VBLANK_DEF = 32'd1;
    // Maximum ce_in pulses to wait for bus_idle before forcing the halt.
    localparam int unsigned WAIT_MAX_DEF     = 32'd1024;

endpackage

// File: rtl/pause_edge.sv
// -----------------------------------------------------------------------------
// pause_edge
// Registered rising-edge detector: rise = sig_in & ~sig_q. The register reset
// value is a parameter so that an input already high when reset is released
// does not look like a fresh edge.
// Ports:
//   clk     in  clock
//   rst_n   in  asynchronous active-low reset
//   sig_in  in  level to watch
//   rise    out high for the cycle in which sig_in goes 0 -> 1
// -----------------------------------------------------------------------------
module pause_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise
);

    logic sig_d;
    logic sig_q;

    // Next value of the delay register is simply the current input level.
    always_comb begin
        sig_d = sig_in;
    end

    // One-cycle delay of the watched level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= RST_VAL;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/pause_sync.sv
// -----------------------------------------------------------------------------
// pause_sync
// Brings the CPU to a clean halt on request: optionally waits for the start of
// vblank, then gates the CPU clock-enable at the next bus boundary (or forces
// the halt after WAIT_MAX ce pulses), and releases it when the request drops.
// Optional feature macro: PAUSE_FRAME_STEP_EN adds a frame_step input that runs
// the CPU for one frame while paused.
// Ports:
//   clk_sys       in  system clock
//   reset_n       in  asynchronous active-low reset
//   pause_req     in  pause request (active-high)
//   ce_in         in  ungated CPU clock-enable pulse
//   bus_idle      in  CPU at an instruction / bus-cycle boundary
//   vblank        in  video vertical blank
//   frame_step    in  one-frame advance while paused (PAUSE_FRAME_STEP_EN only)
//   cpu_ce        out gated CPU clock-enable (combinational from ce_in)
//   paused        out CPU fully halted
//   pause_forced  out current halt was reached by timeout
// -----------------------------------------------------------------------------
module pause_sync
    import pause_pkg::*;
#(
    parameter int unsigned ALIGN_VBLANK = ALIGN_VBLANK_DEF,
    parameter int unsigned WAIT_MAX     = WAIT_MAX_DEF
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic pause_req,
    input  logic ce_in,
    input  logic bus_idle,
    input  logic vblank,
`ifdef PAUSE_FRAME_STEP_EN
    input  logic frame_step,
`endif
    output logic cpu_ce,
    output logic paused,
    output logic pause_forced
);

    // Counter value at which the next un-idle ce pulse forces the halt.
    localparam logic [15:0] CNT_LAST = 16'(WAIT_MAX - 32'd1);

    pause_state_t state_d;
    pause_state_t state_q;
    logic [15:0]  cnt_d;
    logic [15:0]  cnt_q;
    logic         paused_d;
    logic         paused_q;
    logic         pause_forced_d;
    logic         pause_forced_q;
    logic         timeout;
    logic         vrise;
    logic         step_rise;

    // Reset value 1 keeps a vblank already high at reset release from
    // registering as an edge.
    pause_edge #(
        .RST_VAL (1'b1)
    ) u_vblank_edge (
        .clk    (clk_sys),
        .rst_n  (reset_n),
        .sig_in (vblank),
        .rise   (vrise)
    );

`ifdef PAUSE_FRAME_STEP_EN
    pause_edge #(
        .RST_VAL (1'b1)
    ) u_step_edge (
        .clk    (clk_sys),
        .rst_n  (reset_n),
        .sig_in (frame_step),
        .rise   (step_rise)
    );
`else
    // Without frame stepping STEP has no way in.
    assign step_rise = 1'b0;
`endif

    // Next-state and clock-enable gating.
    always_comb begin
        state_d = state_q;
        cpu_ce  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            ST_RUN: begin
                cpu_ce = ce_in;
                if (pause_req) begin
                    if (ALIGN_VBLANK != 32'd0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_HALT_WAIT;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                cpu_ce = ce_in;
                if (!pause_req) begin
                    state_d = ST_RUN;
                end else if (vrise) begin
                    state_d = ST_HALT_WAIT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALT_WAIT: begin
                // The pulse that meets bus_idle, or the last allowed pulse
                // without it, is swallowed so the CPU stops cleanly.
                timeout = ce_in & ~bus_idle & (cnt_q == CNT_LAST);
                cpu_ce  = ce_in & ~bus_idle & ~timeout;
                if (!pause_req) begin
                    state_d = ST_RUN;
                end else if (ce_in & bus_idle) begin
                    state_d = ST_PAUSED;
                end else if (timeout) begin
                    state_d = ST_PAUSED;
                end else begin
                    state_d = ST_HALT_WAIT;
                end
            end
            ST_PAUSED: begin
                cpu_ce = 1'b0;
                if (!pause_req) begin
                    state_d = ST_RUN;
                end else if (step_rise) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            ST_STEP: begin
                cpu_ce = ce_in;
                if (!pause_req) begin
                    state_d = ST_RUN;
                end else if (vrise) begin
                    state_d = ST_HALT_WAIT;
                end else begin
                    state_d = ST_STEP;
                end
            end
            default: begin
                cpu_ce  = ce_in;
                state_d = ST_RUN;
            end
        endcase
    end

    // HALT_WAIT pulse counter; held at zero outside HALT_WAIT so every entry
    // starts a fresh count.
    always_comb begin
        if (state_q == ST_HALT_WAIT) begin
            if (ce_in) begin
                cnt_d = cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = 16'd0;
        end
    end

    // Status flags track the next state so they are exact copies of PAUSED;
    // the forced flag survives only while the halt it describes lasts.
    always_comb begin
        paused_d       = (state_d == ST_PAUSED);
        pause_forced_d = (state_d == ST_PAUSED) & (timeout | pause_forced_q);
    end

    // State, counter and status registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_RUN;
            cnt_q          <= 16'd0;
            paused_q       <= 1'b0;
            pause_forced_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            paused_q       <= paused_d;
            pause_forced_q <= pause_forced_d;
        end
    end

    assign paused       = paused_q;
    assign pause_forced = pause_forced_q;

endmodule

// File: tb/tb_pause_sync.sv
// -----------------------------------------------------------------------------
// tb_pause_sync
// Directed bench for pause_sync. Two instances: dut_a with default parameters
// (vblank-aligned halt, long timeout) and dut_b with ALIGN_VBLANK=0,
// WAIT_MAX=8. They share every input except pause_req.
// -----------------------------------------------------------------------------
module tb_pause_sync;

    logic clk_sys;
    logic reset_n;
    logic req_a;
    logic req_b;
    logic ce_in;
    logic bus_idle;
    logic vblank;
`ifdef PAUSE_FRAME_STEP_EN
    logic frame_step;
`endif
    logic cpu_ce_a;
    logic paused_a;
    logic forced_a;
    logic cpu_ce_b;
    logic paused_b;
    logic forced_b;

    int n_vec = 0;
    int n_err = 0;

    pause_sync dut_a (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .pause_req    (req_a),
        .ce_in        (ce_in),
        .bus_idle     (bus_idle),
        .vblank       (vblank),
`ifdef PAUSE_FRAME_STEP_EN
        .frame_step   (frame_step),
`endif
        .cpu_ce       (cpu_ce_a),
        .paused       (paused_a),
        .pause_forced (forced_a)
    );

    pause_sync #(
        .ALIGN_VBLANK (32'd0),
        .WAIT_MAX     (32'd8)
    ) dut_b (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .pause_req    (req_b),
        .ce_in        (ce_in),
        .bus_idle     (bus_idle),
        .vblank       (vblank),
`ifdef PAUSE_FRAME_STEP_EN
        .frame_step   (frame_step),
`endif
        .cpu_ce       (cpu_ce_b),
        .paused       (paused_b),
        .pause_forced (forced_b)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        req_a    = 1'b0;
        req_b    = 1'b0;
        ce_in    = 1'b1;
        bus_idle = 1'b0;
        vblank   = 1'b0;
`ifdef PAUSE_FRAME_STEP_EN
        frame_step = 1'b0;
`endif
        #2;
        // Reset state: cpu_ce follows ce_in, flags low.
        chk("rst_cpu_ce_a", cpu_ce_a, 1'b1);
        chk("rst_paused_a", paused_a, 1'b0);
        chk("rst_forced_a", forced_a, 1'b0);
        chk("rst_paused_b", paused_b, 1'b0);
        ce_in = 1'b0;
        #1;
        chk("rst_cpu_ce_low", cpu_ce_a, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Aligned halt: ce every 4th cycle, vblank rises at k=6,
        // first ce after that (k=8) is swallowed, paused from k=9.
        for (int k = 0; k < 14; k++) begin
            req_a    = 1'b1;
            bus_idle = 1'b1;
            ce_in    = ((k % 4) == 0);
            vblank   = (k >= 6);
            #1;
            chk($sformatf("align_cpu_ce_k%0d", k), cpu_ce_a, ce_in & (k < 8));
            chk($sformatf("align_paused_k%0d", k), paused_a, (k >= 9));
            chk($sformatf("align_forced_k%0d", k), forced_a, 1'b0);
            tick();
        end

        // Release from PAUSED: paused holds this cycle, clears next,
        // and the next ce passes.
        req_a = 1'b0;
        ce_in = 1'b0;
        #1;
        chk("resume_paused_hold", paused_a, 1'b1);
        chk("resume_cpu_ce_gated", cpu_ce_a, 1'b0);
        tick();
        ce_in = 1'b1;
        #1;
        chk("resume_paused_clr", paused_a, 1'b0);
        chk("resume_cpu_ce", cpu_ce_a, 1'b1);
        tick();

        // Drop request in DRAIN.
        ce_in  = 1'b0;
        vblank = 1'b0;
        tick();
        req_a = 1'b1;
        tick();                           // now DRAIN
        req_a    = 1'b0;
        ce_in    = 1'b1;
        bus_idle = 1'b1;
        #1;
        chk("drain_drop_cpu_ce", cpu_ce_a, 1'b1);
        tick();                           // back in RUN
        // A vblank edge in RUN must not skip DRAIN on re-request.
        req_a  = 1'b1;
        ce_in  = 1'b0;
        vblank = 1'b1;
        tick();                           // DRAIN again
        ce_in = 1'b1;
        #1;
        chk("drain_redrain_cpu_ce", cpu_ce_a, 1'b1);
        tick();
        req_a = 1'b0;
        ce_in = 1'b0;
        #1;
        chk("drain_drop_paused", paused_a, 1'b0);
        tick();

        // Drop request in HALT_WAIT (dut_b halts without vblank alignment).
        req_b    = 1'b1;
        bus_idle = 1'b0;
        tick();                           // HALT_WAIT
        ce_in = 1'b1;
        #1;
        chk("hw_pass_cpu_ce", cpu_ce_b, 1'b1);
        tick();
        req_b = 1'b0;
        ce_in = 1'b0;
        tick();                           // RUN
        ce_in    = 1'b1;
        bus_idle = 1'b1;
        #1;
        chk("hw_drop_cpu_ce", cpu_ce_b, 1'b1);
        tick();
        ce_in = 1'b0;
        #1;
        chk("hw_drop_paused", paused_b, 1'b0);

        // Timeout: WAIT_MAX=8, bus never idle, ce on odd cycles.
        // Pulses 1..7 (j=1..13) pass, pulse 8 (j=15) is swallowed.
        req_b    = 1'b1;
        bus_idle = 1'b0;
        tick();                           // HALT_WAIT, count 0
        for (int j = 1; j < 18; j++) begin
            ce_in = j[0];
            #1;
            chk($sformatf("tmo_cpu_ce_j%0d", j), cpu_ce_b, ce_in & (j < 15));
            chk($sformatf("tmo_paused_j%0d", j), paused_b, (j >= 16));
            chk($sformatf("tmo_forced_j%0d", j), forced_b, (j >= 16));
            tick();
        end
        req_b = 1'b0;
        ce_in = 1'b0;
        tick();
        #1;
        chk("tmo_release_paused", paused_b, 1'b0);
        chk("tmo_release_forced", forced_b, 1'b0);

        // Reset mid-halt with vblank high.
        vblank = 1'b0;
        tick();
        req_a = 1'b1;
        tick();                           // DRAIN
        vblank = 1'b1;
        tick();                           // HALT_WAIT
        ce_in    = 1'b1;
        bus_idle = 1'b1;
        #1;
        chk("rst_mid_pre_cpu_ce", cpu_ce_a, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_cpu_ce", cpu_ce_a, 1'b1);
        chk("rst_mid_paused", paused_a, 1'b0);
        ce_in = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();                           // RUN -> DRAIN, no vblank edge seen
        ce_in = 1'b1;
        #1;
        chk("rst_rel_drain_cpu_ce", cpu_ce_a, 1'b1);
        tick();
        ce_in = 1'b0;
        #1;
        chk("rst_rel_paused", paused_a, 1'b0);

`ifdef PAUSE_FRAME_STEP_EN
        // Frame step: pause, step one frame, re-halt.
        vblank = 1'b0;
        tick();                           // DRAIN, vblank low
        vblank = 1'b1;
        tick();                           // HALT_WAIT
        ce_in = 1'b1;
        tick();                           // PAUSED
        ce_in = 1'b0;
        #1;
        chk("step_paused", paused_a, 1'b1);
        frame_step = 1'b1;
        tick();                           // STEP
        vblank = 1'b0;
        ce_in  = 1'b1;
        #1;
        chk("step_paused_clr", paused_a, 1'b0);
        chk("step_cpu_ce_0", cpu_ce_a, 1'b1);
        tick();
        #1;
        chk("step_cpu_ce_1", cpu_ce_a, 1'b1);
        vblank = 1'b1;
        #1;
        chk("step_cpu_ce_vrise", cpu_ce_a, 1'b1);
        tick();                           // HALT_WAIT
        #1;
        chk("step_rehalt_cpu_ce", cpu_ce_a, 1'b0);
        tick();
        ce_in = 1'b0;
        #1;
        chk("step_rehalt_paused", paused_a, 1'b1);
        frame_step = 1'b0;
        req_a      = 1'b0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pause_sync.md
PAUSE_SYNC -- requirements
Module: pause_sync

Interface
REQ-001 Parameter ALIGN_VBLANK, default 1, meaning: 1 = a halt begins only after a vblank rising edge; 0 = a halt begins immediately.
REQ-002 Parameter WAIT_MAX, default 1024, meaning: the maximum number of ce_in pulses to wait for bus_idle before forcing the halt (range 2..65535).
REQ-003 clk_sys  in  1  core system clock; the only clock in the block.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 pause_req  in  1  pause request, driven from the pause_cpu output of the pause module (active-high).
REQ-006 ce_in  in  1  ungated CPU clock-enable pulse.
REQ-007 bus_idle  in  1  CPU is at an instruction or bus-cycle boundary (active-high).
REQ-008 vblank  in  1  video vertical blank (active-high).
REQ-009 frame_step  in  1  advance exactly one frame while paused; this port exists only when PAUSE_FRAME_STEP_EN is defined.
REQ-010 cpu_ce  out  1  gated clock-enable to the CPU.
REQ-011 paused  out  1  acknowledge: the CPU is fully halted.
REQ-012 pause_forced  out  1  the current halt was reached by timeout rather than by bus_idle.

Function
REQ-013 The block SHALL implement the FSM states RUN, DRAIN, HALT_WAIT, PAUSED and STEP.
REQ-014 cpu_ce SHALL equal ce_in combinationally in RUN, DRAIN and STEP, and SHALL be 0 in PAUSED.
REQ-015 vblank edge detection SHALL be registered: vrise = vblank & ~vblank_q.
REQ-016 RUN SHALL transition on pause_req=1 as follows:
  - to DRAIN if ALIGN_VBLANK=1;
  - to HALT_WAIT otherwise.
REQ-017 DRAIN SHALL transition on vrise to HALT_WAIT, and on pause_req=0 to RUN; pause_req=0 takes priority.
REQ-018 HALT_WAIT cpu_ce SHALL equal ce_in & ~bus_idle, so the ce pulse that coincides with bus_idle is suppressed.
REQ-019 HALT_WAIT SHALL transition as follows:
  - on ce_in & bus_idle, to PAUSED;
  - on pause_req=0, to RUN, with priority over all other HALT_WAIT events.
REQ-020 HALT_WAIT SHALL count ce_in pulses in a 16-bit counter, which is cleared on entry to HALT_WAIT.
REQ-021 When the counter reaches WAIT_MAX-1 and a ce_in pulse occurs without bus_idle, that pulse SHALL be suppressed, the state SHALL go to PAUSED, and pause_forced SHALL be set.
REQ-022 paused SHALL be registered and equal 1 exactly while the state is PAUSED, i.e. one cycle after the halting ce pulse.
REQ-023 PAUSED SHALL transition to RUN on pause_req=0 in the next cycle, with paused and pause_forced cleared on that transition.
REQ-024 A pause_req that toggles during the final cycle of a transition SHALL be evaluated in the following cycle; no request is lost and no partial ce pulse is generated.

Reset
REQ-025 While reset_n=0, the block SHALL hold: state=RUN, paused=0, pause_forced=0, counter=0, vblank_q=1, frame_step_q=1.
REQ-026 cpu_ce SHALL follow ce_in during reset.
REQ-027 Deassertion of reset_n SHALL NOT create a spurious vrise or step edge.
REQ-028 Asserting reset_n=0 mid-halt SHALL return the block to RUN asynchronously.

Configuration
REQ-029 With PAUSE_FRAME_STEP_EN defined, the block SHALL behave as follows:
  - a frame_step rising edge in PAUSED moves to STEP, with paused=0 and pause_forced cleared;
  - STEP moves on vrise to HALT_WAIT, re-halting through the normal bus_idle path;
  - pause_req=0 in STEP moves to RUN;
  - frame_step edges in any other state are ignored.
REQ-030 Without PAUSE_FRAME_STEP_EN, the frame_step port and its register SHALL be absent and STEP SHALL be unreachable.

Structure
REQ-031 The shared package pause_pkg SHALL hold the FSM state typedef and the defaults for ALIGN_VBLANK and WAIT_MAX.
REQ-032 The sub-module pause_edge (registered rising-edge detector, reset value parameterised) SHALL be used for both vblank and frame_step.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
  - ALIGN_VBLANK=1; pause_req=1, ce_in every 4th cycle, bus_idle=1 -> cpu_ce keeps pulsing until the vrise, the first ce after vrise is suppressed, and paused=1 the next cycle with pause_forced=0.
  - ALIGN_VBLANK=0, WAIT_MAX=8, bus_idle held 0 -> exactly 7 ce pulses pass, the 8th is suppressed, then paused=1 and pause_forced=1.
  - pause_req dropped while in DRAIN, and separately while in HALT_WAIT -> RUN in 1 cycle, no ce suppressed, paused never 1.
  - In PAUSED, pause_req=0 -> paused=0 next cycle and cpu_ce resumes on the next ce_in.
  - reset_n pulsed low while in HALT_WAIT with vblank=1 -> RUN immediately and no DRAIN exit on the first cycle after release.
  - PAUSE_FRAME_STEP_EN defined: a frame_step pulse while PAUSED -> ce passes for exactly one frame (until the next vrise), then the block re-halts and paused=1.
